// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one Avalon-MM master port between the instruction-fetch
// and data-memory request sides, with one transaction outstanding at a time.
module mem_port_arbiter #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       TIMEOUT  = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEADBEEF)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_read_en,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_readdata,
  output logic                i_stall,
  input  logic                d_read_en,
  input  logic                d_write_en,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_writedata,
  input  logic [DATA_W/8-1:0] d_byteenable,
  output logic [DATA_W-1:0]   d_readdata,
  output logic                d_stall,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_read,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  output logic [DATA_W/8-1:0] avm_byteenable,
  input  logic                avm_waitrequest,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_readdatavalid,
  output logic                bus_error,
  output logic                busy
);
  localparam int unsigned BE_W     = DATA_W / 8;
  localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;

  state_t              state, state_n;
  logic                grant_d, last_d, gnt_d_n;
  logic                cmd_write;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [DATA_W-1:0]   cmd_wdata;
  logic [BE_W-1:0]     cmd_be;
  logic [7:0]          tmo_cnt;
  logic [DATA_W-1:0]   i_rdata, d_rdata, rd_data;
  logic                bus_err;
  logic                d_req, tmo_last, timeout, rd_done;

  assign d_req    = d_read_en | d_write_en;
  assign tmo_last = (tmo_cnt == TMO_LAST);
  // Data wins unless it also won last time and the instruction side is waiting.
  assign gnt_d_n  = d_req & ~(last_d & i_read_en);
  assign rd_data  = timeout ? ERR_DATA : avm_readdata;

  always_comb begin
    state_n = state;
    timeout = 1'b0;
    rd_done = 1'b0;
    case (state)
      IDLE: if (d_req || i_read_en) state_n = ISSUE;
      ISSUE: begin
        if (!avm_waitrequest && cmd_write) begin
          state_n = RESP;
        end else if (tmo_last) begin
          state_n = RESP;
          timeout = 1'b1;
        end else if (!avm_waitrequest) begin
          state_n = WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (avm_readdatavalid) begin
          state_n = RESP;
          rd_done = 1'b1;
        end else if (tmo_last) begin
          state_n = RESP;
          timeout = 1'b1;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_d   <= 1'b0;
      last_d    <= 1'b0;
      cmd_write <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      cmd_be    <= '0;
      tmo_cnt   <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      bus_err   <= 1'b0;
    end else begin
      if (state == IDLE && state_n == ISSUE) begin
        grant_d   <= gnt_d_n;
        last_d    <= gnt_d_n;
        cmd_write <= gnt_d_n & d_write_en;
        cmd_addr  <= gnt_d_n ? d_addr : i_addr;
        cmd_wdata <= gnt_d_n ? d_writedata : '0;
        cmd_be    <= gnt_d_n ? d_byteenable : '1;
        tmo_cnt   <= '0;
      end else if (state == ISSUE || state == WAIT_RD) begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end
      if (timeout) bus_err <= 1'b1;
      // Data lands on the edge into RESP, only for a side still requesting.
      if (rd_done || (timeout && !cmd_write)) begin
        if (grant_d && d_req)      d_rdata <= rd_data;
        if (!grant_d && i_read_en) i_rdata <= rd_data;
      end
    end
  end

  assign avm_read       = (state == ISSUE) & ~cmd_write;
  assign avm_write      = (state == ISSUE) & cmd_write;
  assign avm_address    = cmd_addr;
  assign avm_writedata  = cmd_wdata;
  assign avm_byteenable = cmd_be;
  assign i_readdata     = i_rdata;
  assign d_readdata     = d_rdata;
  assign bus_error      = bus_err;
  assign busy           = (state != IDLE);
  assign i_stall        = reset & i_read_en & ~((state == RESP) & ~grant_d);
  assign d_stall        = reset & d_req & ~((state == RESP) & grant_d);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised bench for mem_port_arbiter: a transaction-level model predicts grants,
// completion cycles, readdata routing, timeouts and bus_error.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int T  = 8;
  localparam logic [DW-1:0] ERR = 32'hDEADBEEF;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          i_read_en = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_readdata;
  logic          i_stall;
  logic          d_read_en = 1'b0;
  logic          d_write_en = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_writedata = '0;
  logic [BW-1:0] d_byteenable = '0;
  logic [DW-1:0] d_readdata;
  logic          d_stall;
  logic [AW-1:0] avm_address;
  logic          avm_read, avm_write;
  logic [DW-1:0] avm_writedata;
  logic [BW-1:0] avm_byteenable;
  logic          avm_waitrequest = 1'b0;
  logic [DW-1:0] avm_readdata = '0;
  logic          avm_readdatavalid = 1'b0;
  logic          bus_error, busy;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(T), .ERR_DATA(ERR)) dut (
    .clk(clk), .reset(reset),
    .i_read_en(i_read_en), .i_addr(i_addr), .i_readdata(i_readdata), .i_stall(i_stall),
    .d_read_en(d_read_en), .d_write_en(d_write_en), .d_addr(d_addr),
    .d_writedata(d_writedata), .d_byteenable(d_byteenable), .d_readdata(d_readdata),
    .d_stall(d_stall),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .bus_error(bus_error), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Requester state
  bit            i_req;
  logic [AW-1:0] i_a;
  bit            d_rd, d_wr, d_wdrawn;
  logic [AW-1:0] d_a;
  logic [DW-1:0] d_wd;
  logic [BW-1:0] d_be;
  // Transaction model: off counts cycles since ISSUE entry, resp is the RESP offset
  bit            in_txn, g_d, g_wr, to, last_d;
  int            off, resp, W, L;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wd, rdat;
  logic [BW-1:0] c_be;
  logic [DW-1:0] exp_i, exp_d;
  bit            exp_err;
  bit            cont, gen_on, force_rd_on;
  int            force_w = -1, force_l = -1;
  logic [DW-1:0] force_rd;

  function automatic bit dq();
    return d_rd | d_wr;
  endfunction

  task automatic new_i();
    i_req = 1'b1;
    i_a   = $urandom;
  endtask

  task automatic new_d();
    int unsigned r;
    r    = $urandom_range(9);
    d_a  = $urandom;
    d_wd = $urandom;
    d_be = 4'($urandom);
    if (r < 4)      begin d_wr = 1'b1; d_rd = 1'b0; end
    else if (r < 5) begin d_wr = 1'b1; d_rd = 1'b1; end
    else            begin d_wr = 1'b0; d_rd = 1'b1; end
  endtask

  task automatic cycle();
    bit issue;
    int iss_last;
    if (gen_on && !i_req && (cont || $urandom_range(3) == 0)) new_i();
    if (gen_on && !dq() && !d_wdrawn && (cont || $urandom_range(3) == 0)) new_d();
    if (gen_on && !cont && in_txn && g_d && dq() && off > 0 && off < resp &&
        $urandom_range(15) == 0) begin
      d_rd = 1'b0; d_wr = 1'b0; d_wdrawn = 1'b1;
    end
    i_read_en = i_req; i_addr = i_a;
    d_read_en = d_rd; d_write_en = d_wr; d_addr = d_a; d_writedata = d_wd; d_byteenable = d_be;
    if (in_txn && off < W)       avm_waitrequest = 1'b1;
    else if (in_txn && off == W) avm_waitrequest = 1'b0;
    else                         avm_waitrequest = 1'($urandom);
    avm_readdata = $urandom;
    if (in_txn && !g_wr && !to && off == W + L) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = rdat;
    end else if (!in_txn || off <= W || off >= resp) begin
      avm_readdatavalid = ($urandom_range(7) == 0);
    end else begin
      avm_readdatavalid = 1'b0;
    end
    #1;
    iss_last = (W < T - 1) ? W : T - 1;
    issue    = in_txn && off <= iss_last;
    check("busy", 64'(busy), 64'(in_txn));
    check("i_stall", 64'(i_stall), 64'(i_req && !(in_txn && off == resp && !g_d)));
    check("d_stall", 64'(d_stall), 64'(dq() && !(in_txn && off == resp && g_d)));
    check("avm_read", 64'(avm_read), 64'(issue && !g_wr));
    check("avm_write", 64'(avm_write), 64'(issue && g_wr));
    if (issue) begin
      check("avm_address", 64'(avm_address), 64'(c_addr));
      check("avm_byteenable", 64'(avm_byteenable), 64'(c_be));
      if (g_wr) check("avm_writedata", 64'(avm_writedata), 64'(c_wd));
    end
    check("i_readdata", 64'(i_readdata), 64'(exp_i));
    check("d_readdata", 64'(d_readdata), 64'(exp_d));
    check("bus_error", 64'(bus_error), 64'(exp_err));
    @(posedge clk);
    if (in_txn) begin
      if (off == resp) begin
        in_txn   = 1'b0;
        d_wdrawn = 1'b0;
        if (g_d) begin
          if (dq()) begin
            if (gen_on && (cont || $urandom_range(1) == 0)) new_d();
            else begin d_rd = 1'b0; d_wr = 1'b0; end
          end
        end else begin
          if (gen_on && (cont || $urandom_range(1) == 0)) new_i();
          else i_req = 1'b0;
        end
      end else begin
        off++;
        if (off == resp) begin
          if (to) exp_err = 1'b1;
          if (!g_wr) begin
            if (g_d && dq())   exp_d = to ? ERR : rdat;
            if (!g_d && i_req) exp_i = to ? ERR : rdat;
          end
        end
      end
    end else if (i_req || dq()) begin
      g_d    = dq() && !(last_d && i_req);
      last_d = g_d;
      g_wr   = g_d && d_wr;
      c_addr = g_d ? d_a : i_a;
      c_be   = g_d ? d_be : '1;
      c_wd   = d_wd;
      W = (force_w >= 0) ? force_w
        : (($urandom_range(4) == 0) ? int'($urandom_range(11)) : int'($urandom_range(2)));
      L = (force_l >= 0) ? force_l
        : (($urandom_range(4) == 0) ? 1 + int'($urandom_range(9)) : 1 + int'($urandom_range(1)));
      rdat = force_rd_on ? force_rd : $urandom;
      if (g_wr) begin
        to   = (W > T - 1);
        resp = to ? T : W + 1;
      end else begin
        to   = (W + L > T - 1);
        resp = to ? T : W + 1 + L;
      end
      in_txn = 1'b1;
      off    = 0;
    end
    #1;
  endtask

  task automatic quiesce();
    gen_on = 1'b0;
    cont   = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (!in_txn && !i_req && !dq()) break;
      cycle();
    end
  endtask

  task automatic run_one(input bit sd, input bit wr, input int w, input int l,
                         input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input bit fr, input logic [DW-1:0] rd);
    quiesce();
    force_w = w; force_l = l; force_rd_on = fr; force_rd = rd;
    if (sd) begin
      d_rd = !wr; d_wr = wr; d_a = a; d_wd = wd; d_be = 4'hF;
    end else begin
      i_req = 1'b1; i_a = a;
    end
    for (int n = 0; n < 60; n++) begin
      cycle();
      if (!in_txn && !i_req && !dq()) break;
    end
    force_w = -1; force_l = -1; force_rd_on = 1'b0;
  endtask

  task automatic reset_during(input int w, input int l, input int at);
    quiesce();
    force_w = w; force_l = l;
    i_req = 1'b1; i_a = $urandom;
    d_rd = 1'b1; d_wr = 1'b0; d_a = $urandom; d_be = 4'hF;
    for (int n = 0; n < 30; n++) begin
      cycle();
      if (in_txn && off == at) break;
    end
    #2;
    reset = 1'b0;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_i_stall", 64'(i_stall), 64'd0);
    check("rst_d_stall", 64'(d_stall), 64'd0);
    check("rst_avm_read", 64'(avm_read), 64'd0);
    check("rst_avm_write", 64'(avm_write), 64'd0);
    check("rst_i_readdata", 64'(i_readdata), 64'd0);
    check("rst_d_readdata", 64'(d_readdata), 64'd0);
    check("rst_bus_error", 64'(bus_error), 64'd0);
    i_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
    i_read_en = 1'b0; d_read_en = 1'b0; d_write_en = 1'b0; avm_readdatavalid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    avm_readdatavalid = 1'b1;
    avm_readdata      = $urandom;
    avm_waitrequest   = 1'b0;
    @(posedge clk); #1;
    avm_readdatavalid = 1'b0;
    #1;
    check("late_valid_busy", 64'(busy), 64'd0);
    check("late_valid_i_readdata", 64'(i_readdata), 64'd0);
    check("late_valid_d_readdata", 64'(d_readdata), 64'd0);
    in_txn = 1'b0; last_d = 1'b0; exp_i = '0; exp_d = '0; exp_err = 1'b0;
    d_wdrawn = 1'b0; force_w = -1; force_l = -1; force_rd_on = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    gen_on = 1'b0; cont = 1'b0; last_d = 1'b0; in_txn = 1'b0;
    exp_i = '0; exp_d = '0; exp_err = 1'b0;
    i_a = '0; d_a = '0; d_wd = '0; d_be = '0;
    repeat (3) @(posedge clk);
    #1;
    check("init_busy", 64'(busy), 64'd0);
    check("init_avm_read", 64'(avm_read), 64'd0);
    check("init_avm_write", 64'(avm_write), 64'd0);
    check("init_i_readdata", 64'(i_readdata), 64'd0);
    check("init_d_readdata", 64'(d_readdata), 64'd0);
    check("init_bus_error", 64'(bus_error), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    run_one(1'b0, 1'b0, 0, 1, 32'h40, '0, 1'b1, 32'h00500093);
    run_one(1'b1, 1'b1, 3, 1, 32'h1000, 32'h12345678, 1'b0, '0);
    run_one(1'b1, 1'b0, 0, 20, 32'h2000, '0, 1'b1, 32'h11112222);
    run_one(1'b1, 1'b0, 1, 2, 32'h2004, '0, 1'b1, 32'h33334444);
    run_one(1'b0, 1'b0, 12, 1, 32'h80, '0, 1'b0, '0);

    gen_on = 1'b1; cont = 1'b1;
    repeat (80) cycle();
    cont = 1'b0;
    repeat (3000) cycle();

    reset_during(4, 1, 2);
    reset_during(0, 20, 2);
    gen_on = 1'b1; cont = 1'b1;
    repeat (40) cycle();
    cont = 1'b0;
    repeat (300) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares a single Avalon-MM memory master port between the core's instruction-fetch and data-memory request interfaces. It serialises requests, inserts stalls into the requesting pipeline side, and returns read data. The block sits between the core's memory signals and the system interconnect, so instruction and data memory can live behind one port. It handles waitrequest back-pressure, variable read latency (readdatavalid) and a bounded bus timeout.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width; byteenable width is `DATA_W/8`.
- `TIMEOUT`, 255, max cycles spent in ISSUE or WAIT_RD before forced completion; 8-bit counter, legal 1..255.
- `ERR_DATA`, 32'hDEADBEEF, readdata returned on timeout.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `i_read_en`  in  1  instruction read request; held stable while `i_stall`=1.
- `i_addr`  in  ADDR_W  instruction address.
- `i_readdata`  out  DATA_W  registered instruction read data.
- `i_stall`  out  1  instruction side must hold its request.
- `d_read_en`  in  1  data read request.
- `d_write_en`  in  1  data write request; wins if asserted with `d_read_en`.
- `d_addr`  in  ADDR_W  data address.
- `d_writedata`  in  DATA_W  write data.
- `d_byteenable`  in  DATA_W/8  byte lanes.
- `d_readdata`  out  DATA_W  registered data read data.
- `d_stall`  out  1  data side must hold its request.
- `avm_address`  out  ADDR_W  bus address.
- `avm_read`  out  1  bus read.
- `avm_write`  out  1  bus write.
- `avm_writedata`  out  DATA_W  bus write data.
- `avm_byteenable`  out  DATA_W/8  bus byte lanes (4'b1111 for instruction reads at DATA_W=32).
- `avm_waitrequest`  in  1  slave not accepting.
- `avm_readdata`  in  DATA_W  bus read data.
- `avm_readdatavalid`  in  1  read data valid.
- `bus_error`  out  1  sticky, set on any timeout, cleared only by reset.
- `busy`  out  1  FSM not in IDLE.

## Operation
- **FSM states:** IDLE, ISSUE, WAIT_RD, RESP.
- **IDLE.** Sample requests and pick a grant, then go to ISSUE. The granted request's address, writedata, byteenable and kind are latched into command registers.
  - Data has priority.
  - Exception: if the previous grant was data and both sides request, the instruction side wins. Simultaneous requests therefore alternate D, I, D, I.
- **ISSUE.** Drive `avm_read` or `avm_write` plus the command registers.
  - Write accepted (`avm_waitrequest`=0): go to RESP.
  - Read accepted: go to WAIT_RD.
- **WAIT_RD.** On `avm_readdatavalid`=1, latch `avm_readdata` into the granted side's readdata register and go to RESP. `avm_readdatavalid` outside WAIT_RD is ignored.
- **RESP.** One cycle; go to IDLE.
- **Stalls (combinational).**
  - `x_stall` = request asserted AND NOT (state==RESP AND grant==x).
  - In RESP the granted side sees stall=0 for exactly one cycle. That is its completion.
- **Readdata registers.** Each side's readdata register holds its value until that side's next read completion. Writes leave `d_readdata` unchanged.
- **Timeout.** The counter clears on entry to ISSUE and increments in ISSUE and WAIT_RD.
  - Reaching `TIMEOUT` forces RESP, sets `bus_error`, and drops `avm_read`/`avm_write`.
  - A read completes with `ERR_DATA`.
- **Request withdrawn after grant.** The bus transaction still completes and the FSM still passes through RESP. No data is delivered to the side, because its register updates only if its request is still asserted in RESP.
- **Reset (async, mid-transaction).** All outputs drop immediately and state goes to IDLE.
  - Reset values: readdata registers 0, `bus_error`=0, last grant = instruction.
  - An in-flight readdatavalid after reset is ignored.

## Timing
- Read, zero-wait slave, readdatavalid one cycle after accept:
  - c0: IDLE, request seen, stall=1.
  - c1: ISSUE, `avm_read`=1.
  - c2: WAIT_RD, valid arrives.
  - c3: RESP, stall=0, readdata valid.
  - c4: IDLE.
  - Stall lasts 3 cycles.
- Write, zero-wait: c0 IDLE, c1 ISSUE, c2 RESP (stall=0). Stall lasts 2 cycles.
- Each waitrequest cycle adds one cycle in ISSUE, and each readdatavalid delay cycle adds one cycle in WAIT_RD.
- Bus outputs are registered and stable for the whole ISSUE state.
- Only one transaction is outstanding at any time.

## Test plan
- **Isolated instruction read.** Stimulus: `i_read_en`=1 with `i_addr`=0x40, zero-wait slave returning 0x00500093.
  - `avm_read` high only in c1.
  - `i_stall` high c0–c2 and low in c3.
  - `i_readdata`=0x00500093 from c3 onward.
- **Data write under back-pressure.** Stimulus: write 0x12345678 to 0x1000 with waitrequest held 3 cycles.
  - `avm_write`/`avm_address`/`avm_writedata` stable for 4 cycles.
  - `d_stall` low exactly one cycle later.
  - `d_readdata` unchanged.
- **Simultaneous read requests.** Stimulus: I and D read requests both held continuously.
  - First grant is D.
  - Grants then alternate D, I, D, I, each with correct readdata routing.
- **Timeout.** Stimulus: a read whose slave never asserts readdatavalid, `TIMEOUT`=8.
  - RESP is reached after 8 cycles in ISSUE+WAIT_RD.
  - `d_readdata`=0xDEADBEEF and `bus_error`=1, held.
  - A next request proceeds normally.
- **Async reset in WAIT_RD.** Stimulus: reset goes low in WAIT_RD, then readdatavalid=1 arrives the cycle after release.
  - `avm_read`, `busy` and stalls drop without a clock edge.
  - The late readdatavalid is ignored and readdata registers stay 0.
